program_counter_sequencer: RTL and testbench

Control FSM that sequences the CPU's program counter register: fetch handshake, instruction decode, the selection and timing of every PC write, and the trap entry path. Drives the PC register's `writeEnable`/`writeDataSource` inputs using the `PC_SOURCE_*` codes from `ProgramCounterConstants.inc.v`. Also pulses an exception-PC capture strobe, so the old PC is saved before the PC register loads a trap vector.

---
 rtl/program_counter_sequencer.sv | 167 ++++++++++++++++
 tb/tb_program_counter_sequencer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_counter_sequencer.sv
// program_counter_sequencer
//
// Control FSM for the CPU program counter. It runs the instruction fetch
// handshake, waits for the decoder, chooses which source the PC register loads
// and when, and runs the two-step trap entry. In trap entry the exception PC is
// captured first and the trap vector is loaded on the next cycle.
//
// Optional build macro: PC_SEQUENCER_INTERRUPT_EN
//   defined   - interruptRequest seen at an instruction boundary (DECODE) traps
//               to the exception vector in place of running the instruction.
//   undefined - interruptRequest is accepted on the port but has no effect.
//
// Ports
//   clock              in   rising-edge clock
//   reset              in   synchronous, active-high; forces IDLE
//   fetchReady         in   instruction word for the current PC is available
//   fetchFault         in   fetch fault, qualified by fetchReady
//   fetchTlbMiss       in   user-space fetch TLB miss, qualified by fetchReady
//   instructionValid   in   decoder outputs are stable
//   instructionKind    in   0 seq, 1 branch, 2 jump, 3 jump-reg, 4 halt, 5-7 illegal
//   branchTaken        in   branch condition for kind 1
//   executeFault       in   execute/data exception, qualified by instructionValid
//   executeTlbMiss     in   user-space data TLB miss, qualified by instructionValid
//   interruptRequest   in   pending unmasked interrupt
//   fetchRequest       out  fetch at the current PC
//   pcWriteEnable      out  PC register write strobe
//   pcWriteDataSource  out  PC source select (PC_SOURCE_* codes)
//   epcCapture         out  save the current PC into the exception PC register
//   halted             out  sequencer has stopped

module program_counter_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic       fetchReady,
    input  logic       fetchFault,
    input  logic       fetchTlbMiss,
    input  logic       instructionValid,
    input  logic [2:0] instructionKind,
    input  logic       branchTaken,
    input  logic       executeFault,
    input  logic       executeTlbMiss,
    input  logic       interruptRequest,
    output logic       fetchRequest,
    output logic       pcWriteEnable,
    output logic [2:0] pcWriteDataSource,
    output logic       epcCapture,
    output logic       halted
);

    // PC source codes shared with the PC register (ProgramCounterConstants).
    localparam logic [2:0] PC_SOURCE_INCREMENT     = 3'd0;
    localparam logic [2:0] PC_SOURCE_ADD_IMMEDIATE = 3'd1;
    localparam logic [2:0] PC_SOURCE_ADD_OFFSET    = 3'd2;
    localparam logic [2:0] PC_SOURCE_EXPLICIT      = 3'd3;
    localparam logic [2:0] PC_SOURCE_EXCEPTION     = 3'd4;
    localparam logic [2:0] PC_SOURCE_USER_TLB_MISS = 3'd5;

    localparam logic [2:0] STATE_IDLE        = 3'd0;
    localparam logic [2:0] STATE_FETCH       = 3'd1;
    localparam logic [2:0] STATE_DECODE      = 3'd2;
    localparam logic [2:0] STATE_UPDATE      = 3'd3;
    localparam logic [2:0] STATE_TRAP_SAVE   = 3'd4;
    localparam logic [2:0] STATE_TRAP_VECTOR = 3'd5;
    localparam logic [2:0] STATE_HALT        = 3'd6;

    logic [2:0] r_state;
    logic [2:0] r_source;
    logic [2:0] w_nextState;
    logic [2:0] w_nextSource;
    logic       w_interruptTrap;

`ifdef PC_SEQUENCER_INTERRUPT_EN
    assign w_interruptTrap = interruptRequest;
`else
    // The port stays for pin compatibility; masking it to zero keeps it
    // referenced while guaranteeing it never influences the sequence.
    assign w_interruptTrap = interruptRequest & 1'b0;
`endif

    // Next-state logic. The same source register carries the PC source for a
    // normal update and the trap vector select, so UPDATE and TRAP_VECTOR
    // both just present r_source.
    always_comb begin
        w_nextState  = r_state;
        w_nextSource = r_source;
        case (r_state)
            STATE_IDLE: begin
                w_nextState = STATE_FETCH;
            end
            STATE_FETCH: begin
                if (fetchReady) begin
                    if (fetchTlbMiss) begin
                        w_nextState  = STATE_TRAP_SAVE;
                        w_nextSource = PC_SOURCE_USER_TLB_MISS;
                    end else if (fetchFault) begin
                        w_nextState  = STATE_TRAP_SAVE;
                        w_nextSource = PC_SOURCE_EXCEPTION;
                    end else begin
                        w_nextState = STATE_DECODE;
                    end
                end
            end
            STATE_DECODE: begin
                // Priority: data TLB miss, execute fault, illegal kind,
                // interrupt, halt, then the normal PC update.
                if (instructionValid) begin
                    if (executeTlbMiss) begin
                        w_nextState  = STATE_TRAP_SAVE;
                        w_nextSource = PC_SOURCE_USER_TLB_MISS;
                    end else if (executeFault || (instructionKind > 3'd4) || w_interruptTrap) begin
                        w_nextState  = STATE_TRAP_SAVE;
                        w_nextSource = PC_SOURCE_EXCEPTION;
                    end else if (instructionKind == 3'd4) begin
                        w_nextState = STATE_HALT;
                    end else begin
                        w_nextState = STATE_UPDATE;
                        case (instructionKind)
                            3'd1:    w_nextSource = branchTaken ? PC_SOURCE_ADD_IMMEDIATE
                                                                : PC_SOURCE_INCREMENT;
                            3'd2:    w_nextSource = PC_SOURCE_ADD_OFFSET;
                            3'd3:    w_nextSource = PC_SOURCE_EXPLICIT;
                            default: w_nextSource = PC_SOURCE_INCREMENT;
                        endcase
                    end
                end
            end
            STATE_UPDATE:      w_nextState = STATE_FETCH;
            STATE_TRAP_SAVE:   w_nextState = STATE_TRAP_VECTOR;
            STATE_TRAP_VECTOR: w_nextState = STATE_FETCH;
            STATE_HALT:        w_nextState = STATE_HALT;
            default:           w_nextState = STATE_IDLE;
        endcase
    end

    // State and source registers; reset wins from every state, so an update
    // or trap in flight is abandoned cleanly.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= STATE_IDLE;
            r_source <= PC_SOURCE_INCREMENT;
        end else begin
            r_state  <= w_nextState;
            r_source <= w_nextSource;
        end
    end

    // Moore outputs. The source select idles at INCREMENT whenever no write
    // is in progress so the PC register input is never undefined.
    always_comb begin
        fetchRequest      = 1'b0;
        pcWriteEnable     = 1'b0;
        pcWriteDataSource = PC_SOURCE_INCREMENT;
        epcCapture        = 1'b0;
        halted            = 1'b0;
        case (r_state)
            STATE_FETCH: fetchRequest = 1'b1;
            STATE_UPDATE, STATE_TRAP_VECTOR: begin
                pcWriteEnable     = 1'b1;
                pcWriteDataSource = r_source;
            end
            STATE_TRAP_SAVE: epcCapture = 1'b1;
            STATE_HALT:      halted     = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_program_counter_sequencer.sv
// tb_program_counter_sequencer
//
// Drives instruction transactions (fetch handshake, decode handshake) into the
// sequencer. For each one, the expected PC-write / EPC / halt events and the
// cycle each should appear in are queued by a reference model. A monitor pops
// and compares whenever the sequencer raises one of those outputs.

module tb_program_counter_sequencer;

    localparam logic [2:0] SRC_INC  = 3'd0;
    localparam logic [2:0] SRC_IMM  = 3'd1;
    localparam logic [2:0] SRC_OFF  = 3'd2;
    localparam logic [2:0] SRC_EXPL = 3'd3;
    localparam logic [2:0] SRC_EXC  = 3'd4;
    localparam logic [2:0] SRC_TLB  = 3'd5;

    localparam int EV_WRITE = 0;
    localparam int EV_EPC   = 1;
    localparam int EV_HALT  = 2;

    localparam int RESP_WRITE = 0;
    localparam int RESP_TRAP  = 1;
    localparam int RESP_HALT  = 2;

`ifdef PC_SEQUENCER_INTERRUPT_EN
    localparam bit IRQ_ENABLED = 1'b1;
`else
    localparam bit IRQ_ENABLED = 1'b0;
`endif

    typedef struct {
        int         fetchWait;
        bit         fTlb;
        bit         fFault;
        int         decodeWait;
        logic [2:0] kind;
        bit         taken;
        bit         exFault;
        bit         exTlb;
        bit         irq;
        bit         irqInFetch;
    } instr_t;

    typedef struct {
        int         evType;
        logic [2:0] src;
        int         cycle;
    } expect_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       fetchReady;
    logic       fetchFault;
    logic       fetchTlbMiss;
    logic       instructionValid;
    logic [2:0] instructionKind;
    logic       branchTaken;
    logic       executeFault;
    logic       executeTlbMiss;
    logic       interruptRequest;
    logic       fetchRequest;
    logic       pcWriteEnable;
    logic [2:0] pcWriteDataSource;
    logic       epcCapture;
    logic       halted;

    expect_t expQ[$];
    int      errors = 0;
    int      checks = 0;
    int      cyc = 0;
    int      expNextFetch = 0;
    bit      monitorOn = 1'b0;

    program_counter_sequencer dut (
        .clock             (clock),
        .reset             (reset),
        .fetchReady        (fetchReady),
        .fetchFault        (fetchFault),
        .fetchTlbMiss      (fetchTlbMiss),
        .instructionValid  (instructionValid),
        .instructionKind   (instructionKind),
        .branchTaken       (branchTaken),
        .executeFault      (executeFault),
        .executeTlbMiss    (executeTlbMiss),
        .interruptRequest  (interruptRequest),
        .fetchRequest      (fetchRequest),
        .pcWriteEnable     (pcWriteEnable),
        .pcWriteDataSource (pcWriteDataSource),
        .epcCapture        (epcCapture),
        .halted            (halted)
    );

    // Free-running clock and cycle index; the index read at a falling edge
    // names the cycle whose outputs are being observed.
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic void pushExp(input int evType, input logic [2:0] src, input int cycle);
        expect_t e;
        e.evType = evType;
        e.src    = src;
        e.cycle  = cycle;
        expQ.push_back(e);
    endfunction

    // Reference model: what the sequencer must do with one instruction,
    // straight from the trap / halt / update rules.
    function automatic void modelResponse(input instr_t t, output int resp, output logic [2:0] src);
        logic [2:0] updateSrc [4];
        updateSrc[0] = SRC_INC;
        updateSrc[1] = t.taken ? SRC_IMM : SRC_INC;
        updateSrc[2] = SRC_OFF;
        updateSrc[3] = SRC_EXPL;
        resp = RESP_TRAP;
        src  = SRC_EXC;
        if (t.fTlb)                      src = SRC_TLB;
        else if (t.fFault)               src = SRC_EXC;
        else if (t.exTlb)                src = SRC_TLB;
        else if (t.exFault)              src = SRC_EXC;
        else if (t.kind >= 3'd5)         src = SRC_EXC;
        else if (t.irq && IRQ_ENABLED)   src = SRC_EXC;
        else if (t.kind == 3'd4)         resp = RESP_HALT;
        else begin
            resp = RESP_WRITE;
            src  = updateSrc[t.kind[1:0]];
        end
    endfunction

    function automatic instr_t mkInstr(input logic [2:0] kind, input bit taken);
        instr_t t;
        t.fetchWait  = 0;
        t.fTlb       = 1'b0;
        t.fFault     = 1'b0;
        t.decodeWait = 0;
        t.kind       = kind;
        t.taken      = taken;
        t.exFault    = 1'b0;
        t.exTlb      = 1'b0;
        t.irq        = 1'b0;
        t.irqInFetch = 1'b0;
        return t;
    endfunction

    task automatic clearInputs();
        fetchReady       = 1'b0;
        fetchFault       = 1'b0;
        fetchTlbMiss     = 1'b0;
        instructionValid = 1'b0;
        instructionKind  = 3'd0;
        branchTaken      = 1'b0;
        executeFault     = 1'b0;
        executeTlbMiss   = 1'b0;
        interruptRequest = 1'b0;
    endtask

    // Called at a falling edge: holds reset across one rising edge, checks
    // the IDLE outputs, releases reset and predicts the first fetch cycle.
    task automatic doReset();
        logic [6:0] outs;
        reset = 1'b1;
        clearInputs();
        @(posedge clock);
        @(negedge clock);
        outs = {fetchRequest, pcWriteEnable, epcCapture, halted, pcWriteDataSource};
        checkOutput("idleOutputs", {25'd0, outs}, 32'd0);
        checkOutput("pendingAtReset", expQ.size(), 0);
        expQ.delete();
        reset = 1'b0;
        expNextFetch = cyc + 1;
    endtask

    task automatic waitForFetch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (fetchRequest === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            checkOutput("fetchStartCycle", cyc, expNextFetch);
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL fetchTimeout: got no fetchRequest, expected one at cycle %0d", expNextFetch);
        end
    endtask

    // One instruction: fetch handshake, optional decode handshake, queue the
    // expected events. resetMid asserts reset in the first response cycle.
    task automatic applyStimulus(input instr_t t, input bit resetMid, input int haltHold);
        bit         ok;
        int         resp;
        logic [2:0] src;
        int         a;
        int         d;
        modelResponse(t, resp, src);
        waitForFetch(ok);
        if (!ok) begin
            doReset();
            return;
        end
        interruptRequest = t.irqInFetch;
        for (int w = 0; w < t.fetchWait; w++) begin
            fetchReady   = 1'b0;
            fetchFault   = 1'($urandom_range(0, 1));
            fetchTlbMiss = 1'($urandom_range(0, 1));
            @(negedge clock);
            checkOutput("fetchHeld", fetchRequest, 1);
        end
        fetchReady   = 1'b1;
        fetchFault   = t.fFault;
        fetchTlbMiss = t.fTlb;
        a = cyc;
        if (t.fTlb || t.fFault) begin
            pushExp(EV_EPC, SRC_INC, a + 1);
            if (!resetMid) pushExp(EV_WRITE, src, a + 2);
        end
        @(negedge clock);
        fetchReady       = 1'b0;
        fetchFault       = 1'b0;
        fetchTlbMiss     = 1'b0;
        interruptRequest = 1'b0;
        if (t.fTlb || t.fFault) begin
            if (resetMid) doReset();
            else expNextFetch = a + 3;
            return;
        end
        for (int w = 0; w < t.decodeWait; w++) begin
            instructionValid = 1'b0;
            instructionKind  = 3'($urandom_range(0, 7));
            branchTaken      = 1'($urandom_range(0, 1));
            executeFault     = 1'($urandom_range(0, 1));
            executeTlbMiss   = 1'($urandom_range(0, 1));
            interruptRequest = 1'($urandom_range(0, 1));
            @(negedge clock);
        end
        instructionValid = 1'b1;
        instructionKind  = t.kind;
        branchTaken      = t.taken;
        executeFault     = t.exFault;
        executeTlbMiss   = t.exTlb;
        interruptRequest = t.irq;
        d = cyc;
        case (resp)
            RESP_WRITE: pushExp(EV_WRITE, src, d + 1);
            RESP_TRAP: begin
                pushExp(EV_EPC, SRC_INC, d + 1);
                if (!resetMid) pushExp(EV_WRITE, src, d + 2);
            end
            default: pushExp(EV_HALT, SRC_INC, d + 1);
        endcase
        @(negedge clock);
        clearInputs();
        if (resetMid) begin
            doReset();
            return;
        end
        if (resp == RESP_WRITE) begin
            expNextFetch = d + 2;
        end else if (resp == RESP_TRAP) begin
            expNextFetch = d + 3;
        end else begin
            for (int h = 0; h < haltHold; h++) begin
                fetchReady       = 1'b1;
                instructionValid = 1'b1;
                instructionKind  = 3'($urandom_range(0, 3));
                @(negedge clock);
                checkOutput("haltHeld", {30'd0, halted, fetchRequest}, 32'd2);
            end
            doReset();
        end
    endtask

    // Monitor: per-cycle output invariants plus scoreboard compare on every
    // write, EPC capture or halt entry.
    initial begin
        int      evType;
        expect_t e;
        bit      invariantOk;
        bit      prevHalted;
        prevHalted = 1'b0;
        forever begin
            @(negedge clock);
            if (monitorOn) begin
                invariantOk = !(epcCapture === 1'b1 && pcWriteEnable === 1'b1) &&
                              (pcWriteEnable === 1'b1 || pcWriteDataSource === SRC_INC);
                checkOutput("invariants", {31'd0, invariantOk}, 32'd1);
                evType = -1;
                if (pcWriteEnable === 1'b1)                    evType = EV_WRITE;
                else if (epcCapture === 1'b1)                  evType = EV_EPC;
                else if (halted === 1'b1 && !prevHalted)       evType = EV_HALT;
                prevHalted = (halted === 1'b1);
                if (evType >= 0) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpectedEvent: got type %0d src %0d at cycle %0d, expected no event",
                                 evType, pcWriteDataSource, cyc);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("eventType", evType, e.evType);
                        checkOutput("eventSource", {29'd0, pcWriteDataSource}, {29'd0, e.src});
                        checkOutput("eventCycle", cyc, e.cycle);
                    end
                end
            end
        end
    end

    // Directed scenarios first, then a randomized run.
    initial begin
        instr_t t;
        clearInputs();
        reset = 1'b1;
        @(negedge clock);
        doReset();
        monitorOn = 1'b1;

        $display("[TB] sequential instructions, zero-wait handshakes");
        t = mkInstr(3'd0, 1'b0);
        repeat (3) applyStimulus(t, 1'b0, 0);

        $display("[TB] branch taken / not taken, jump with fetch wait, jump-register");
        applyStimulus(mkInstr(3'd1, 1'b1), 1'b0, 0);
        applyStimulus(mkInstr(3'd1, 1'b0), 1'b0, 0);
        t = mkInstr(3'd2, 1'b0);
        t.fetchWait = 4;
        applyStimulus(t, 1'b0, 0);
        applyStimulus(mkInstr(3'd3, 1'b0), 1'b0, 0);
        t = mkInstr(3'd1, 1'b1);
        t.decodeWait = 3;
        applyStimulus(t, 1'b0, 0);

        $display("[TB] traps");
        t = mkInstr(3'd0, 1'b0);
        t.exFault = 1'b1;
        t.exTlb   = 1'b1;
        applyStimulus(t, 1'b0, 0);
        t = mkInstr(3'd0, 1'b0);
        t.fFault = 1'b1;
        applyStimulus(t, 1'b0, 0);
        t = mkInstr(3'd0, 1'b0);
        t.fTlb   = 1'b1;
        t.fFault = 1'b1;
        applyStimulus(t, 1'b0, 0);
        applyStimulus(mkInstr(3'd6, 1'b0), 1'b0, 0);
        applyStimulus(mkInstr(3'd7, 1'b0), 1'b0, 0);

        $display("[TB] halt and recovery");
        applyStimulus(mkInstr(3'd4, 1'b0), 1'b0, 20);
        applyStimulus(mkInstr(3'd0, 1'b0), 1'b0, 0);

        $display("[TB] reset during update and during trap save");
        applyStimulus(mkInstr(3'd2, 1'b0), 1'b1, 0);
        t = mkInstr(3'd0, 1'b0);
        t.exFault = 1'b1;
        applyStimulus(t, 1'b1, 0);
        applyStimulus(mkInstr(3'd0, 1'b0), 1'b0, 0);

        $display("[TB] interrupt at decode and during fetch");
        t = mkInstr(3'd0, 1'b0);
        t.irq = 1'b1;
        applyStimulus(t, 1'b0, 0);
        t = mkInstr(3'd0, 1'b0);
        t.irqInFetch = 1'b1;
        t.fetchWait  = 2;
        applyStimulus(t, 1'b0, 0);
        t = mkInstr(3'd4, 1'b0);
        t.irq = 1'b1;
        applyStimulus(t, 1'b0, 3);

        $display("[TB] randomized instructions");
        for (int n = 0; n < 80; n++) begin
            t.fetchWait  = $urandom_range(0, 3);
            t.fTlb       = ($urandom_range(0, 9) == 0);
            t.fFault     = ($urandom_range(0, 9) == 0);
            t.decodeWait = $urandom_range(0, 3);
            t.kind       = 3'($urandom_range(0, 7));
            t.taken      = 1'($urandom_range(0, 1));
            t.exFault    = ($urandom_range(0, 9) == 0);
            t.exTlb      = ($urandom_range(0, 9) == 0);
            t.irq        = ($urandom_range(0, 3) == 0);
            t.irqInFetch = ($urandom_range(0, 3) == 0);
            applyStimulus(t, ($urandom_range(0, 11) == 0), 3);
        end

        repeat (4) @(negedge clock);
        checkOutput("queueDrained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
